// File: rtl/cushion_queue_if.sv
// Exec->mread cushion queue bus: push handshake, head handshake and
// register-forwarding query, grouped for the queue and its neighbours.
interface cushion_queue_if #(
  parameter int DATA_WIDTH = 96,
  parameter int RD_WIDTH   = 5
);
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [RD_WIDTH-1:0]   IN_RD;
  logic                  IN_RD_VALID;
  logic [31:0]           IN_RD_DATA;
  logic [DATA_WIDTH-1:0] IN_PAYLOAD;

  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [RD_WIDTH-1:0]   OUT_RD;
  logic                  OUT_RD_VALID;
  logic [31:0]           OUT_RD_DATA;
  logic [DATA_WIDTH-1:0] OUT_PAYLOAD;

  logic [RD_WIDTH-1:0]   FWD_ADDR;
  logic                  FWD_HIT;
  logic                  FWD_PENDING;
  logic [31:0]           FWD_DATA;

  modport master (
    output IN_VALID, IN_RD, IN_RD_VALID,
    output IN_RD_DATA, IN_PAYLOAD,
    input  IN_READY,
    input  OUT_VALID, OUT_RD, OUT_RD_VALID,
    input  OUT_RD_DATA, OUT_PAYLOAD,
    output OUT_READY,
    output FWD_ADDR,
    input  FWD_HIT, FWD_PENDING, FWD_DATA
  );

  modport slave (
    input  IN_VALID, IN_RD, IN_RD_VALID,
    input  IN_RD_DATA, IN_PAYLOAD,
    output IN_READY,
    output OUT_VALID, OUT_RD, OUT_RD_VALID,
    output OUT_RD_DATA, OUT_PAYLOAD,
    input  OUT_READY,
    input  FWD_ADDR,
    output FWD_HIT, FWD_PENDING, FWD_DATA
  );
endinterface

// File: rtl/cushion_queue.sv
// DEPTH-entry in-order exec->mread FIFO with newest-first forwarding.
// Optional occupancy statistics: define CUSHION_QUEUE_STATS_EN.
module cushion_queue #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 4,
  parameter int RD_WIDTH   = 5,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          MEM_WAIT,
  cushion_queue_if.slave bus,
  output logic [CW-1:0] COUNT,
  output logic [31:0]   STAT_FULL_CYCLES,
  output logic [CW-1:0] STAT_MAX_COUNT
);

  logic [RD_WIDTH-1:0]   rd_q   [DEPTH];
  logic [31:0]           data_q [DEPTH];
  logic [DATA_WIDTH-1:0] pay_q  [DEPTH];
  logic [DEPTH-1:0]      rdv_q;
  logic [DEPTH-1:0]      vld_q;
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign COUNT = cnt_q;

  // No full-queue bypass: a full queue refuses even when popping.
  assign bus.IN_READY = !full && !MEM_WAIT;
  assign push = bus.IN_VALID && bus.IN_READY && !FLUSH;
  assign pop  = !empty && bus.OUT_READY && !MEM_WAIT && !FLUSH;

  always_comb begin
    cnt_d = cnt_q;
    if (FLUSH)
      cnt_d = '0;
    else if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (FLUSH) begin
        wptr_q <= '0;
        rptr_q <= '0;
        vld_q  <= '0;
      end else begin
        if (push) begin
          wptr_q         <= wptr_q + PW'(1);
          vld_q[wptr_q]  <= 1'b1;
        end
        if (pop) begin
          rptr_q         <= rptr_q + PW'(1);
          vld_q[rptr_q]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      rd_q[wptr_q]   <= bus.IN_RD;
      rdv_q[wptr_q]  <= bus.IN_RD_VALID;
      data_q[wptr_q] <= bus.IN_RD_DATA;
      pay_q[wptr_q]  <= bus.IN_PAYLOAD;
    end
  end

  assign bus.OUT_VALID    = !empty;
  assign bus.OUT_RD       = empty ? '0 : rd_q[rptr_q];
  assign bus.OUT_RD_VALID = empty ? 1'b0 : rdv_q[rptr_q];
  assign bus.OUT_RD_DATA  = empty ? '0 : data_q[rptr_q];
  assign bus.OUT_PAYLOAD  = empty ? '0 : pay_q[rptr_q];

  logic        fwd_hit;
  logic        fwd_pend;
  logic [31:0] fwd_data;

  // Walk oldest to newest so the newest match is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_pend = 1'b0;
    fwd_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wptr_q - PW'(k) - PW'(1);
      if (vld_q[idx] && bus.FWD_ADDR != '0 &&
          rd_q[idx] == bus.FWD_ADDR) begin
        fwd_hit  = rdv_q[idx];
        fwd_pend = !rdv_q[idx];
        fwd_data = rdv_q[idx] ? data_q[idx] : '0;
      end
    end
  end

  assign bus.FWD_HIT     = fwd_hit;
  assign bus.FWD_PENDING = fwd_pend;
  assign bus.FWD_DATA    = fwd_data;

`ifdef CUSHION_QUEUE_STATS_EN
  logic [31:0]   full_cyc_q;
  logic [CW-1:0] max_q;

  // FLUSH deliberately leaves these alone; only reset clears them.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full_cyc_q <= '0;
      max_q      <= '0;
    end else begin
      if (full && full_cyc_q != '1)
        full_cyc_q <= full_cyc_q + 32'd1;
      if (cnt_d > max_q)
        max_q <= cnt_d;
    end
  end

  assign STAT_FULL_CYCLES = full_cyc_q;
  assign STAT_MAX_COUNT   = max_q;
`else
  assign STAT_FULL_CYCLES = '0;
  assign STAT_MAX_COUNT   = '0;
`endif

endmodule

// File: tb/tb_cushion_queue.sv
// Randomized scoreboard bench for cushion_queue against a queue-based
// reference model of occupancy, ordering and forwarding.
module tb_cushion_queue;
  localparam int DW    = 96;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [RW-1:0] rd;
    logic          rdv;
    logic [31:0]   data;
    logic [DW-1:0] pay;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          mem_wait = 1'b0;
  logic [CW-1:0] count;
  logic [31:0]   stat_full;
  logic [CW-1:0] stat_max;

  cushion_queue_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) bus();

  cushion_queue #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .RD_WIDTH(RW)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .FLUSH(flush),
    .MEM_WAIT(mem_wait),
    .bus(bus),
    .COUNT(count),
    .STAT_FULL_CYCLES(stat_full),
    .STAT_MAX_COUNT(stat_max)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  ent_t mdl[$];
  ent_t sb[$];
  longint m_full = 0;
  int m_max = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.IN_VALID    = 1'b0;
    bus.IN_RD       = '0;
    bus.IN_RD_VALID = 1'b0;
    bus.IN_RD_DATA  = '0;
    bus.IN_PAYLOAD  = '0;
    bus.OUT_READY   = 1'b0;
    bus.FWD_ADDR    = '0;
    flush           = 1'b0;
    mem_wait        = 1'b0;
  endtask

  task automatic check_stats();
`ifdef CUSHION_QUEUE_STATS_EN
    chk("stat_full", stat_full, m_full);
    chk("stat_max", stat_max, m_max);
`else
    chk("stat_full", stat_full, 0);
    chk("stat_max", stat_max, 0);
`endif
  endtask

  // One cycle: drive at negedge, check combinational view, advance model.
  task automatic step(input logic iv, input logic [RW-1:0] rd,
                      input logic rdv, input logic [31:0] data,
                      input logic ordy, input logic mw, input logic fl,
                      input logic [RW-1:0] fa);
    ent_t e;
    logic exp_rdy, push, pop, hit, pend;
    logic [31:0] fdata;
    @(negedge clk);
    e.rd = rd;
    e.rdv = rdv;
    e.data = data;
    e.pay = {$urandom(), $urandom(), $urandom()};
    bus.IN_VALID    = iv;
    bus.IN_RD       = rd;
    bus.IN_RD_VALID = rdv;
    bus.IN_RD_DATA  = data;
    bus.IN_PAYLOAD  = e.pay;
    bus.OUT_READY   = ordy;
    bus.FWD_ADDR    = fa;
    mem_wait        = mw;
    flush           = fl;
    #1;
    exp_rdy = (mdl.size() != DEPTH) && !mw;
    chk("in_ready", bus.IN_READY, exp_rdy);
    chk("out_valid", bus.OUT_VALID, mdl.size() != 0);
    chk("count", count, mdl.size());
    if (mdl.size() == 0) begin
      chk("out_pay_zero", bus.OUT_PAYLOAD, 0);
      chk("out_rd_zero",
          {bus.OUT_RD, bus.OUT_RD_VALID, bus.OUT_RD_DATA}, 0);
    end
    hit = 1'b0;
    pend = 1'b0;
    fdata = '0;
    if (fa != '0) begin
      for (int i = mdl.size() - 1; i >= 0; i--) begin
        if (mdl[i].rd == fa) begin
          hit = mdl[i].rdv;
          pend = !mdl[i].rdv;
          fdata = mdl[i].rdv ? mdl[i].data : 32'd0;
          break;
        end
      end
    end
    chk("fwd_hit", bus.FWD_HIT, hit);
    chk("fwd_pending", bus.FWD_PENDING, pend);
    chk("fwd_data", bus.FWD_DATA, fdata);
    check_stats();
    push = iv && exp_rdy && !fl;
    pop = (mdl.size() > 0) && ordy && !mw && !fl;
    if (mdl.size() == DEPTH && m_full != 64'hFFFF_FFFF) m_full++;
    if (fl) begin
      mdl.delete();
      sb.delete();
    end else begin
      if (pop) void'(mdl.pop_front());
      if (push) begin
        mdl.push_back(e);
        sb.push_back(e);
      end
    end
    if (mdl.size() > m_max) m_max = mdl.size();
  endtask

  task automatic idle(input logic [RW-1:0] fa);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, fa);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_in_ready", bus.IN_READY, 1);
    chk("rst_stat_full", stat_full, 0);
    chk("rst_stat_max", stat_max, 0);
    mdl.delete();
    sb.delete();
    m_full = 0;
    m_max = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every observed head handshake.
  ent_t me;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.OUT_VALID && bus.OUT_READY && !mem_wait && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=pop required=no_pop");
        end else begin
          me = sb.pop_front();
          chk("out_rd", bus.OUT_RD, me.rd);
          chk("out_rd_valid", bus.OUT_RD_VALID, me.rdv);
          chk("out_rd_data", bus.OUT_RD_DATA, me.data);
          chk("out_payload", bus.OUT_PAYLOAD, me.pay);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] held;
    idle_inputs();
    do_reset();

    step(1'b1, 5'd3, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, '0);
    idle('0);
    chk("tp_out_valid", bus.OUT_VALID, 1);
    chk("tp_out_rd", bus.OUT_RD, 3);
    chk("tp_out_data", bus.OUT_RD_DATA, 32'h11);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++)
        step(1'b1, RW'(i + 1), 1'b1, $urandom(), 1'b0, 1'b0, 1'b0, '0);
      idle('0);
      chk("tp_full_count", count, DEPTH);
      chk("tp_full_ready", bus.IN_READY, 0);
      for (int i = 0; i < DEPTH; i++)
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
      idle('0);
      chk("tp_drained", count, 0);
    end

    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 5'd4, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 5'd4, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, '0);
    idle('0);
    chk("tp_full_pop_count", count, DEPTH - 1);
    chk("tp_full_pop_ready", bus.IN_READY, 1);

    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 5'd7, 1'b1, 32'hA, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 5'd7, 1'b0, 32'hDEAD, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 5'd9, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0, '0);
    idle(5'd7);
    chk("tp_fwd7_pend", bus.FWD_PENDING, 1);
    chk("tp_fwd7_hit", bus.FWD_HIT, 0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5'd7);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 5'd7);
    idle(5'd9);
    chk("tp_fwd9_hit", bus.FWD_HIT, 1);
    chk("tp_fwd9_data", bus.FWD_DATA, 32'hB);
    idle('0);
    chk("tp_fwd0_hit", bus.FWD_HIT, 0);

    step(1'b1, 5'd2, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, '0);
    idle('0);
    held = count;
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd5, 1'b1, $urandom(), 1'b1, 1'b1, 1'b0, '0);
    idle('0);
    chk("tp_memwait_count", count, held);
    step(1'b1, 5'd5, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, '0);
    idle('0);
    chk("tp_flush_mw_count", count, 0);

    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 5'd6, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) idle('0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
    idle('0);

    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) do_reset();
      step($urandom_range(0, 3) != 0, RW'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0, $urandom(),
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 40) == 0, RW'($urandom_range(0, 7)));
    end

    for (int i = 0; i < DEPTH + 2; i++)
      step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cushion_queue.md
Name: cushion_queue

Overview:
Parametrised successor to the single-entry exec→mread cushion register: a DEPTH-entry in-order FIFO between the exec stage and memory-read stage. It absorbs MEM_WAIT bubbles without stalling exec. It also provides a newest-first register-forwarding lookup across all buffered entries, with a pending indication for entries whose write data is not yet known (loads). The payload is opaque (packed CSR/mem/jump fields); only rd/data fields are interpreted.

Parameters:
DATA_WIDTH, 96, width of opaque payload bundle carried alongside rd/data
DEPTH, 4, number of entries; power of two, >= 2
RD_WIDTH, 5, register address width

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-low reset
FLUSH  in  1  synchronous clear of all entries (jump taken)
MEM_WAIT  in  1  memory hazard; freezes push and pop
IN_VALID  in  1  exec offers an entry
IN_READY  out  1  queue accepts entry this cycle
IN_RD  in  RD_WIDTH  destination register (0 = none)
IN_RD_VALID  in  1  1: IN_RD_DATA final; 0: value pending (load)
IN_RD_DATA  in  32  register write value
IN_PAYLOAD  in  DATA_WIDTH  opaque bundle
OUT_VALID  out  1  head entry present
OUT_READY  in  1  mread consumes head
OUT_RD  out  RD_WIDTH  head rd
OUT_RD_VALID  out  1  head rd-data-final flag
OUT_RD_DATA  out  32  head register value
OUT_PAYLOAD  out  DATA_WIDTH  head bundle
FWD_ADDR  in  RD_WIDTH  forwarding query address
FWD_HIT  out  1  newest match has final data
FWD_PENDING  out  1  newest match is pending
FWD_DATA  out  32  data of newest match (0 if no hit)
COUNT  out  $clog2(DEPTH)+1  occupancy
STAT_FULL_CYCLES  out  32  see optional feature
STAT_MAX_COUNT  out  $clog2(DEPTH)+1  see optional feature

Behaviour:
- Reset (RST=0, async): write ptr, read ptr and COUNT are 0; all entry valid bits are 0. Outputs: OUT_VALID=0, IN_READY=1, OUT_*=0, FWD_*=0, stats=0.
- Storage: circular buffer with wrap-around pointers of width log2(DEPTH), plus COUNT. Full when COUNT==DEPTH; empty when COUNT==0.
- IN_READY = (COUNT!=DEPTH) && !MEM_WAIT. There is no full-queue bypass: when full, IN_READY=0 even if a pop happens in the same cycle.
- push = IN_VALID && IN_READY && !FLUSH. pop = OUT_VALID && OUT_READY && !MEM_WAIT && !FLUSH.
- Latency: an entry pushed at edge N appears on OUT_* after edge N (the cycle after acceptance) if the queue was empty. There is no combinational in→out path.
- OUT_* read combinationally from the head slot. When empty, OUT_VALID=0 and OUT_RD/OUT_RD_DATA/OUT_PAYLOAD/OUT_RD_VALID are forced to 0.
- Simultaneous push and pop: COUNT is unchanged and both pointers advance.
- FLUSH: at the next edge, COUNT, pointers and valid bits clear; a push or pop in that cycle is discarded. FLUSH takes priority over MEM_WAIT.
- MEM_WAIT=1 (and no FLUSH): state is fully frozen and OUT_* holds stable.
- Forwarding (combinational, stored entries only):
  - Scan valid entries from newest to oldest for rd==FWD_ADDR.
  - FWD_ADDR==0 never matches.
  - First match with RD_VALID=1: FWD_HIT=1, FWD_DATA=entry data, FWD_PENDING=0.
  - First match with RD_VALID=0: FWD_PENDING=1, FWD_HIT=0, FWD_DATA=0.
  - No match: all 0.
  - The entry at IN_* in the current cycle is not searched; the exec-stage forwarding path covers it.
- Entries with IN_RD=0 are stored normally and are never forwarding sources.

Optional Feature:
Macro CUSHION_QUEUE_STATS_EN.
- Defined:
  - STAT_FULL_CYCLES increments every cycle COUNT==DEPTH and saturates at 0xFFFFFFFF.
  - STAT_MAX_COUNT holds the high-water mark of COUNT.
  - Both clear on reset only; FLUSH does not clear them.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Reset with DEPTH=4 → IN_READY=1, OUT_VALID=0, COUNT=0. Push rd=3 data=0x11 → next cycle OUT_VALID=1, OUT_RD=3, OUT_RD_DATA=0x11.
- OUT_READY=0, push 5 entries back-to-back → first 4 accepted, IN_READY=0 on the 5th, COUNT=4. Pop all → data returned in order, COUNT=0, pointers wrap correctly on a second fill.
- Full queue with IN_VALID=1 and OUT_READY=1 in the same cycle → pop only, COUNT 4→3, IN_READY=1 next cycle.
- Forwarding:
  - Push rd=7/0xA (final), then rd=7 pending, then rd=9/0xB; FWD_ADDR=7 → FWD_PENDING=1, FWD_HIT=0.
  - Pop twice; FWD_ADDR=9 → FWD_HIT=1, FWD_DATA=0xB.
  - FWD_ADDR=0 → no hit.
- MEM_WAIT=1 for 3 cycles with IN_VALID=1 and OUT_READY=1 → COUNT and OUT_* unchanged. FLUSH during MEM_WAIT → COUNT=0 next cycle.
- Stats build, fill to full and hold 10 cycles → STAT_FULL_CYCLES=10, STAT_MAX_COUNT=4. After FLUSH, stats are unchanged; after async reset mid-operation, all cleared immediately.
